// File: rtl/col2mtx_fill_if.sv
// rtl/col2mtx_fill_if.sv - stream/matrix bundle between a word producer and col2mtx_fill
interface col2mtx_fill_if #(
  parameter int BITS = 8,
  parameter int DIM  = 32
);
  localparam int W = $clog2(DIM) + 1;

  logic                                 en;
  logic [W-1:0]                         m;
  logic [W-1:0]                         n;
  logic [DIM-1:0]                       IN;
  logic [DIM-1:0][DIM-1:0][BITS-1:0]    OUT;
  logic                                 full;

  modport master (
    output en,
    output m,
    output n,
    output IN,
    input  OUT,
    input  full
  );

  modport slave (
    input  en,
    input  m,
    input  n,
    input  IN,
    output OUT,
    output full
  );
endinterface

// File: rtl/col2mtx_fill.sv
// rtl/col2mtx_fill.sv - packed-word stream to DIM x DIM row-major matrix loader, bounded by m x n
// Optional: COL2MTX_OVERFLOW_DROP_EN suppresses lanes past the m*n region in the final word.
module col2mtx_fill #(
  parameter int BITS = 8,
  parameter int DIM  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  col2mtx_fill_if.slave bus
);
  localparam int LANES = DIM / BITS;
  localparam int AW    = $clog2(DIM);
  localparam int W     = AW + 1;
  localparam int RW    = AW + 2;
  localparam int CW    = 2 * AW + 1;

  logic [DIM-1:0][DIM-1:0][BITS-1:0] out_q;
  logic [RW-1:0]                     row_q;
  logic [W-1:0]                      col_q;
  logic [CW-1:0]                     count_q;
  logic [CW-1:0]                     mn;
  logic                              full;
  logic                              accept;

  logic [RW-1:0]   lane_row [LANES+1];
  logic [W-1:0]    lane_col [LANES+1];
  logic [W:0]      col_inc  [LANES];
  logic [BITS-1:0] lane_data [LANES];
  logic [LANES-1:0] lane_wr;

  assign mn     = CW'(bus.m) * CW'(bus.n);
  assign full   = (count_q >= mn);
  assign accept = bus.en && !full;

  assign bus.OUT  = out_q;
  assign bus.full = full;

  // Per-lane pointer chain: each lane steps one column, wrapping on m, so a
  // single word may wrap several rows when m < LANES.
  always_comb begin
    lane_row[0] = row_q;
    lane_col[0] = col_q;
    lane_wr     = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_data[k] = bus.IN[DIM-1-k*BITS -: BITS];
      col_inc[k]   = {1'b0, lane_col[k]} + (W+1)'(1);
      if (col_inc[k] >= {1'b0, bus.m}) begin
        lane_col[k+1] = '0;
        lane_row[k+1] = lane_row[k] + RW'(1);
      end else begin
        lane_col[k+1] = col_inc[k][W-1:0];
        lane_row[k+1] = lane_row[k];
      end
`ifdef COL2MTX_OVERFLOW_DROP_EN
      lane_wr[k] = accept && (lane_row[k] < RW'(DIM)) && (lane_col[k] < W'(DIM))
                   && ((count_q + CW'(k)) < mn);
`else
      lane_wr[k] = accept && (lane_row[k] < RW'(DIM)) && (lane_col[k] < W'(DIM));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_wr[k]) begin
          out_q[lane_row[k][AW-1:0]][lane_col[k][AW-1:0]] <= lane_data[k];
        end
      end
      row_q   <= lane_row[LANES];
      col_q   <= lane_col[LANES];
      count_q <= count_q + CW'(LANES);
    end
  end
endmodule

// File: tb/tb_col2mtx_fill.sv
// tb/tb_col2mtx_fill.sv - directed self-checking bench for col2mtx_fill
module tb_col2mtx_fill;
  localparam int BITS  = 8;
  localparam int DIM   = 32;
  localparam int LANES = DIM / BITS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  col2mtx_fill_if #(.BITS(BITS), .DIM(DIM)) bus ();
  col2mtx_fill #(.BITS(BITS), .DIM(DIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_m [DIM][DIM];
  int exp_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        exp_m[r][c] = 8'h00;
    exp_count = 0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    bus.en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic set_mn(input int mm, input int nn);
    bus.m = mm[5:0];
    bus.n = nn[5:0];
  endtask

  // Expected placement: element e of the stream lands at row e/m, col e%m.
  task automatic send(input logic [31:0] w, input logic e, input string tag);
    int mm, nn, idx, r, c;
    logic [31:0] word;
    mm = int'(bus.m);
    nn = int'(bus.n);
    word = w;
    bus.IN = w;
    bus.en = e;
    if (e && exp_count < mm * nn) begin
      for (int k = 0; k < LANES; k++) begin
        idx = exp_count + k;
        r = idx / mm;
        c = idx % mm;
`ifdef COL2MTX_OVERFLOW_DROP_EN
        if (r < DIM && idx < mm * nn) exp_m[r][c] = word[31-8*k -: 8];
`else
        if (r < DIM) exp_m[r][c] = word[31-8*k -: 8];
`endif
      end
      exp_count += LANES;
    end
    @(posedge clk); #1;
    bus.en = 1'b0;
    check_eq($sformatf("%s_full_at_%0d", tag, exp_count), {31'd0, bus.full},
             {31'd0, (exp_count >= mm * nn)});
  endtask

  task automatic check_mtx(input string tag);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        check_eq($sformatf("%s_out[%0d][%0d]", tag, r, c), {24'd0, bus.OUT[r][c]}, {24'd0, exp_m[r][c]});
  endtask

  logic [7:0] t3_exp [12] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22,
                             8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    bus.en = 1'b0;
    bus.IN = '0;
    set_mn(10, 10);

    // reset state and 10x10 fill with a trailing ignored word
    do_reset();
    check_eq("rst_full", {31'd0, bus.full}, 32'd0);
    check_mtx("rst");
    for (int i = 0; i < 25; i++) send($urandom, 1'b1, "fill10");
    check_eq("fill10_full", {31'd0, bus.full}, 32'd1);
    send(32'hDEADBEEF, 1'b1, "fill10_extra");
    check_mtx("fill10");

    // 5x5: last word overflows into row 5
    set_mn(5, 5);
    do_reset();
    for (int i = 0; i < 7; i++) send(32'h01020304 + 32'h10101010 * i, 1'b1, "fill5");
    send(32'hCAFEF00D, 1'b1, "fill5_extra");
`ifdef COL2MTX_OVERFLOW_DROP_EN
    check_eq("fill5_row5c0", {24'd0, bus.OUT[5][0]}, 32'h00);
`else
    check_eq("fill5_row5c0", {24'd0, bus.OUT[5][0]}, 32'h62);
`endif
    check_mtx("fill5");

    // full 32x32 fill
    set_mn(32, 32);
    do_reset();
    for (int i = 0; i < 256; i++) send($urandom, 1'b1, "fill32");
    send(32'h12345678, 1'b1, "fill32_extra");
    check_mtx("fill32");

    // m=3, n=4 hand-computed
    set_mn(3, 4);
    do_reset();
    send(32'hAABBCCDD, 1'b1, "m3n4");
    send(32'h11223344, 1'b1, "m3n4");
    send(32'h55667788, 1'b1, "m3n4");
    for (int i = 0; i < 12; i++)
      check_eq($sformatf("m3n4_e%0d", i), {24'd0, bus.OUT[i/3][i%3]}, {24'd0, t3_exp[i]});
    check_eq("m3n4_row4", {24'd0, bus.OUT[4][0]}, 32'h00);

    // en toggling keeps data contiguous
    set_mn(10, 10);
    do_reset();
    send(32'hA0A1A2A3, 1'b1, "entog");
    send(32'hFFFFFFFF, 1'b0, "entog");
    send(32'hB0B1B2B3, 1'b1, "entog");
    check_eq("entog_c4", {24'd0, bus.OUT[0][4]}, 32'hB0);
    check_eq("entog_c8", {24'd0, bus.OUT[0][8]}, 32'h00);
    check_mtx("entog");

    // reset mid-fill then complete a fresh fill
    do_reset();
    for (int i = 0; i < 10; i++) send($urandom, 1'b1, "midrst");
    do_reset();
    check_eq("midrst_full", {31'd0, bus.full}, 32'd0);
    check_mtx("midrst_clr");
    for (int i = 0; i < 25; i++) send($urandom, 1'b1, "refill");
    check_mtx("refill");

    // m*n == 0 blocks all writes
    set_mn(0, 10);
    do_reset();
    check_eq("zero_full", {31'd0, bus.full}, 32'd1);
    send(32'h5A5A5A5A, 1'b1, "zero");
    check_eq("zero_out00", {24'd0, bus.OUT[0][0]}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/col2mtx_fill.md
Name: col2mtx_fill

Overview:
- Stream-to-matrix loader for the accelerator.
- Packed words of LANES = DIM/BITS elements arrive one per enabled cycle and are written row-major into a DIM x DIM register matrix.
- Fill is bounded by a runtime m (columns) x n (rows) region.
- The matrix feeds downstream compute in parallel; full flags completion.

Parameters:
- BITS, 8, element width in bits.
- DIM, 32, matrix dimension and input word width in bits; DIM must be a multiple of BITS (LANES = DIM/BITS, 4 by default).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  when high and not full, IN is consumed this cycle.
- m  in  $clog2(DIM)+1  active column count (1..DIM).
- n  in  $clog2(DIM)+1  active row count (1..DIM).
- IN  in  DIM  packed elements; lane 0 = IN[DIM-1 -: BITS] (MSB first), lane k = IN[DIM-1-k*BITS -: BITS].
- OUT  out  BITS x [DIM][DIM]  matrix registers, OUT[row][col].
- full  out  1  count of written elements >= m*n.

Behaviour:
- Interface: one clock; reset is synchronous and active-low, ports named clk and rst_n.
- Reset (rst_n low at posedge): all OUT elements <= 0; write pointer row=0, col=0; element count=0. Reset has priority over en and may occur mid-fill; the next fill restarts at [0][0].
- full is combinational: count >= m*n, with an 11-bit product/count for default DIM.
  - After reset with m*n>0, full=0.
  - m*n==0 gives full=1 immediately; all writes are blocked.
- Write cycle (en=1, full=0, rst_n=1): all LANES lanes are written in the same cycle.
  - Lane 0 goes to [row][col].
  - Each subsequent lane advances col by 1; when col+1 reaches m, col wraps to 0 and row increments.
  - The wrap chain is evaluated per lane sequentially, so it is correct for any m>=1, including multiple wraps per word.
  - After the cycle: pointer = position after the last lane; count += LANES.
- Lanes whose computed row >= DIM are discarded. No other bound is checked by default: lanes past the m*n region in the final word are written (e.g. into row n).
- en=0, or full=1: no state change; IN is ignored. A word presented while full is dropped entirely.
- Latency: OUT reflects a word on the first posedge after it is accepted. full updates combinationally from the new count in the same cycle.
- m and n must be held stable from reset through fill completion. Changing them mid-fill changes full immediately but does not re-map data already written.
- Elements outside the written region keep their reset value 0.

Optional Feature:
- Macro COL2MTX_OVERFLOW_DROP_EN.
- Defined: in a write cycle, lanes whose element index (count + lane) >= m*n are not written. The matrix holds exactly the m x n region; count still advances by LANES.
- Undefined: default behaviour above (overflow lanes of the final word are written, limited only by row < DIM).

Test Plan:
- Reset, m=n=10, en=1 for 25 words of random data, then one extra cycle with en=1 -> OUT[r][c] = byte (10r+c)%4 of word (10r+c)/4 (MSB first) for r,c<10; all other elements 0; full=1 after word 25; the extra word is ignored.
- m=n=5, 7 words, en held one extra cycle -> 5x5 region filled row-major; word 6 lanes 1..3 land in OUT[5][0..2] (default build); full=1 after word 7 (count 28>=25); the extra word is ignored. With COL2MTX_OVERFLOW_DROP_EN, OUT[5][0..2] stay 0.
- m=n=32, 256 words -> every element written; full rises exactly after word 256; wrap occurs at each 8-word boundary.
- m=3, n=4, words 0xAABBCCDD, 0x11223344, 0x55667788 -> rows AA BB CC / DD 11 22 / 33 44 55 / 66 77 88; full=1 after 3 words.
- en toggling 1,0,1 with m=n=10 -> the en=0 cycle leaves the pointer and OUT unchanged; data is contiguous.
- Reset asserted after 10 of 25 words (m=n=10) -> OUT all 0, full=0; a fresh fill starts at [0][0] and completes correctly.
